// File: rtl/sd_resp_capture.sv
// sd_resp_capture: assembles CMD-line response words into the Response register
module sd_resp_capture #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 4,
   parameter int CNT_W     = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        resp_start,
   input  logic [1:0]                  resp_type,
   input  logic                        resp_valid,
   input  logic [WORD_W-1:0]           resp_word,
   input  logic                        resp_last,
   input  logic                        clr,
   output logic [WORD_W*NUM_WORDS-1:0] Response_out,
   output logic                        busy,
   output logic                        ack,
   output logic                        err_len
);
   localparam int RW = WORD_W*NUM_WORDS;
   typedef enum logic {IDLE, CAPTURE} state_t;
   state_t state;
   logic [1:0] typ;
   logic [CNT_W-1:0] cnt, exp_cnt;
   logic [RW-WORD_W-1:0] stage;
   logic [RW-1:0] stage_nxt, resp_nxt;
   logic take, hit, commit;
   assign busy = (state == CAPTURE);
   assign exp_cnt = (typ == 2'b10) ? CNT_W'(NUM_WORDS) : CNT_W'(1);
   assign take = busy && resp_valid && !resp_start;
   assign hit = (cnt + CNT_W'(1)) == exp_cnt;
   assign commit = take && hit && resp_last;
   // Words arrive MSW first, so shifting in from the bottom leaves word k at index exp-1-k
   assign stage_nxt = {stage, resp_word};
   // Next Response register value: a commit overrides a simultaneous clear
   always_comb begin
      resp_nxt = clr ? '0 : Response_out;
      if (commit) begin
         resp_nxt = Response_out;
         if (typ == 2'b10) resp_nxt = stage_nxt;
         else if (typ == 2'b11) resp_nxt[RW-1 -: WORD_W] = resp_word;
         else resp_nxt[WORD_W-1:0] = resp_word;
      end
   end
   // Capture FSM with staging, counter, ack pulse and sticky length error
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         typ <= 2'b00;
         cnt <= '0;
         stage <= '0;
         Response_out <= '0;
         ack <= 1'b0;
         err_len <= 1'b0;
      end else begin
         ack <= 1'b0;
         Response_out <= resp_nxt;
         if (resp_start) begin
            err_len <= busy;
            typ <= resp_type;
            cnt <= '0;
            state <= (resp_type == 2'b00) ? IDLE : CAPTURE;
         end else if (take) begin
            stage <= stage_nxt[RW-WORD_W-1:0];
            cnt <= cnt + CNT_W'(1);
            if (hit || resp_last) begin
               state <= IDLE;
               ack <= commit;
               err_len <= err_len | !commit;
            end
         end
      end
   end
endmodule

// File: tb/tb_sd_resp_capture.sv
// tb_sd_resp_capture: directed and randomized checks against a word-list model
module tb_sd_resp_capture;
   localparam int W = 32, N = 4;
   logic clk = 0, rst = 1, resp_start = 0, resp_valid = 0, resp_last = 0, clr = 0;
   logic [1:0] resp_type = 0;
   logic [W-1:0] resp_word = 0;
   logic [W*N-1:0] Response_out;
   logic busy, ack, err_len;
   int checks = 0, fails = 0;
   logic [127:0] m_resp;

   sd_resp_capture #(.WORD_W(W), .NUM_WORDS(N), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .resp_start(resp_start), .resp_type(resp_type),
      .resp_valid(resp_valid), .resp_word(resp_word), .resp_last(resp_last),
      .clr(clr), .Response_out(Response_out), .busy(busy), .ack(ack), .err_len(err_len));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [1:0] t);
      resp_start = 1; resp_type = t;
      step();
      resp_start = 0; resp_type = 0;
   endtask

   task automatic word(input logic [W-1:0] w, input logic last, input logic c);
      resp_valid = 1; resp_word = w; resp_last = last; clr = c;
      step();
      resp_valid = 0; resp_word = 0; resp_last = 0; clr = 0;
   endtask

   function automatic logic [127:0] model(input logic [1:0] t, input logic [31:0] ws[$], input logic [127:0] old);
      logic [127:0] r;
      r = old;
      if (t == 2'b10) for (int i = 0; i < N; i++) r[W*(N-1-i) +: W] = ws[i];
      else if (t == 2'b11) r[127:96] = ws[0];
      else r[31:0] = ws[0];
      return r;
   endfunction

   task automatic test_reset();
      rst = 1; step(); step(); rst = 0;
      checks++; if (Response_out !== '0) begin fails++; $display("FAIL reset_resp got %h want 0", Response_out); end
      checks++; if (busy !== 0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (ack !== 0) begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
      checks++; if (err_len !== 0) begin fails++; $display("FAIL reset_err got %b want 0", err_len); end
   endtask

   task automatic test_long();
      logic [31:0] ws[4] = '{32'hAAAA0003, 32'hBBBB0002, 32'hCCCC0001, 32'hDDDD0000};
      start(2'b10);
      checks++; if (busy !== 1) begin fails++; $display("FAIL long_busy got %b want 1", busy); end
      for (int i = 0; i < 4; i++) begin
         word(ws[i], i == 3, 0);
         if (i < 3) begin
            checks++; if (ack !== 0 || busy !== 1) begin fails++; $display("FAIL long_mid ack/busy got %b%b want 01", ack, busy); end
         end
      end
      checks++; if (Response_out !== 128'hAAAA0003_BBBB0002_CCCC0001_DDDD0000) begin fails++; $display("FAIL long_resp got %h", Response_out); end
      checks++; if (ack !== 1 || busy !== 0 || err_len !== 0) begin fails++; $display("FAIL long_flags ack/busy/err got %b%b%b want 100", ack, busy, err_len); end
      step();
      checks++; if (ack !== 0) begin fails++; $display("FAIL long_ack_pulse got %b want 0", ack); end
   endtask

   task automatic test_short();
      start(2'b01); word(32'h00000900, 1, 0);
      checks++; if (Response_out !== 128'hAAAA0003_BBBB0002_CCCC0001_00000900) begin fails++; $display("FAIL short_resp got %h", Response_out); end
      checks++; if (ack !== 1) begin fails++; $display("FAIL short_ack got %b want 1", ack); end
   endtask

   task automatic test_auto();
      start(2'b11); word(32'h12345678, 1, 0);
      checks++; if (Response_out !== 128'h12345678_BBBB0002_CCCC0001_00000900) begin fails++; $display("FAIL auto_resp got %h", Response_out); end
      checks++; if (ack !== 1) begin fails++; $display("FAIL auto_ack got %b want 1", ack); end
   endtask

   task automatic test_errors();
      logic [127:0] old;
      old = Response_out;
      start(2'b10); word(32'h1, 0, 0); word(32'h2, 1, 0);
      checks++; if (err_len !== 1 || ack !== 0 || busy !== 0) begin fails++; $display("FAIL err_early err/ack/busy got %b%b%b want 100", err_len, ack, busy); end
      checks++; if (Response_out !== old) begin fails++; $display("FAIL err_early_resp got %h want %h", Response_out, old); end
      start(2'b01);
      checks++; if (err_len !== 0) begin fails++; $display("FAIL err_cleared_by_start got %b want 0", err_len); end
      word(32'h3, 0, 0);
      checks++; if (err_len !== 1 || ack !== 0 || busy !== 0) begin fails++; $display("FAIL err_nolast err/ack/busy got %b%b%b want 100", err_len, ack, busy); end
      checks++; if (Response_out !== old) begin fails++; $display("FAIL err_nolast_resp got %h want %h", Response_out, old); end
   endtask

   task automatic test_restart();
      start(2'b10); word(32'h11, 0, 0); word(32'h22, 0, 0);
      start(2'b01);
      checks++; if (err_len !== 1 || ack !== 0 || busy !== 1) begin fails++; $display("FAIL restart err/ack/busy got %b%b%b want 101", err_len, ack, busy); end
      word(32'h00000001, 1, 0);
      checks++; if (ack !== 1 || Response_out[31:0] !== 32'h1 || err_len !== 1) begin fails++; $display("FAIL restart_commit ack=%b w0=%h err=%b want 1 00000001 1", ack, Response_out[31:0], err_len); end
      step();
      checks++; if (ack !== 0) begin fails++; $display("FAIL restart_single_ack got %b want 0", ack); end
   endtask

   task automatic test_clr();
      logic [127:0] exp;
      exp = {Response_out[127:32], 32'hCAFEF00D};
      start(2'b01); word(32'hCAFEF00D, 1, 1);
      checks++; if (Response_out !== exp) begin fails++; $display("FAIL clr_commit got %h want %h", Response_out, exp); end
      clr = 1; step(); clr = 0;
      checks++; if (Response_out !== '0) begin fails++; $display("FAIL clr_idle got %h want 0", Response_out); end
   endtask

   task automatic test_start_with_valid();
      resp_start = 1; resp_type = 2'b01; resp_valid = 1; resp_word = 32'hDEAD; resp_last = 1;
      step();
      resp_start = 0; resp_type = 0; resp_valid = 0; resp_word = 0; resp_last = 0;
      checks++; if (ack !== 0 || busy !== 1) begin fails++; $display("FAIL start_valid ack/busy got %b%b want 01", ack, busy); end
      word(32'h0000BEEF, 1, 0);
      checks++; if (Response_out !== 128'h0000BEEF) begin fails++; $display("FAIL start_valid_resp got %h want 0000beef", Response_out); end
   endtask

   task automatic test_rst_mid();
      start(2'b10); word(32'h5, 0, 0); start(2'b11);
      rst = 1; step(); rst = 0;
      checks++; if (Response_out !== '0 || busy !== 0 || ack !== 0 || err_len !== 0) begin fails++; $display("FAIL rst_mid resp=%h busy=%b ack=%b err=%b want all 0", Response_out, busy, ack, err_len); end
      word(32'h7, 1, 0);
      checks++; if (ack !== 0 || Response_out !== '0) begin fails++; $display("FAIL rst_mid_lost ack=%b resp=%h want 0", ack, Response_out); end
   endtask

   task automatic test_random();
      logic [31:0] ws[$];
      logic [1:0] t;
      int e, k;
      logic last_end, exp_ack, exp_err;
      m_resp = '0;
      for (int it = 0; it < 60; it++) begin
         t = 2'($urandom_range(1, 3));
         e = (t == 2'b10) ? N : 1;
         k = $urandom_range(1, e);
         last_end = (k < e) ? 1'b1 : ($urandom_range(0, 3) != 0);
         start(t);
         ws.delete();
         for (int i = 0; i < k; i++) begin
            repeat ($urandom_range(0, 2)) step();
            ws.push_back($urandom);
            word(ws[i], (i == k - 1) && last_end, 0);
            if (i < k - 1) begin
               checks++; if (ack !== 0 || busy !== 1) begin fails++; $display("FAIL rand_mid it=%0d ack/busy got %b%b want 01", it, ack, busy); end
            end
         end
         exp_ack = (k == e) && last_end;
         exp_err = !exp_ack;
         if (exp_ack) m_resp = model(t, ws, m_resp);
         checks++; if (Response_out !== m_resp) begin fails++; $display("FAIL rand_resp it=%0d got %h want %h", it, Response_out, m_resp); end
         checks++; if (ack !== exp_ack || err_len !== exp_err || busy !== 0) begin fails++; $display("FAIL rand_flags it=%0d ack/err/busy got %b%b%b want %b%b0", it, ack, err_len, busy, exp_ack, exp_err); end
      end
   endtask

   initial begin
      test_reset();
      test_long();
      test_short();
      test_auto();
      test_errors();
      test_restart();
      test_clr();
      test_start_with_valid();
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/sd_resp_capture.md
# sd_resp_capture

Parametrised successor to the SD host 128-bit Response register (offset 010h). It assembles a command response from the CMD-line deserializer, delivered as WORD_W-bit words, into the NUM_WORDS-word Response register. Short, long (R2) and Auto-CMD12 responses each land in their defined slot. The block reports completion and length errors to the interrupt/status logic and sits between the CMD deserializer and the host register file read mux.

## Interface
- WORD_W, 32, width of one response word from the deserializer
- NUM_WORDS, 4, number of words in the Response register; register width is WORD_W*NUM_WORDS (default 128)
- CNT_W, 3, counter width; must hold values 0..NUM_WORDS

Ports:
- clk  in  1  block clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- resp_start  in  1  one-cycle pulse that opens a capture; resp_type is sampled on this cycle
- resp_type  in  2  00 none, 01 short, 10 long (R2), 11 Auto-CMD12
- resp_valid  in  1  resp_word is valid this cycle
- resp_word  in  WORD_W  response word, most-significant word first
- resp_last  in  1  qualifies the final word, meaningful only with resp_valid
- clr  in  1  synchronous clear of Response_out
- Response_out  out  WORD_W*NUM_WORDS  committed Response register contents
- busy  out  1  high while in CAPTURE
- ack  out  1  one-cycle pulse: response committed
- err_len  out  1  sticky length error

## Operation
- FSM states: IDLE and CAPTURE. Reset state is IDLE.
- IDLE + resp_start with type 01, 10 or 11:
  - go to CAPTURE
  - latch the type
  - count <= 0
  - clear err_len
- IDLE + resp_start with type 00: stay in IDLE and clear err_len.
- resp_valid in IDLE is ignored.
- Expected word count: short = 1, long = NUM_WORDS, Auto-CMD12 = 1.
- In CAPTURE, each resp_valid word is written into the staging buffer at word index (expected-1-count), and count increments.
- Commit happens on resp_last when count+1 equals the expected count:
  - short: write word 0 ([WORD_W-1:0]); other words unchanged
  - long: write all words from staging
  - Auto-CMD12: write word NUM_WORDS-1 only; other words unchanged
  - then pulse ack and return to IDLE
- Length errors abort with no commit: err_len <= 1, return to IDLE, no ack. Two cases:
  - resp_last arrives early (count+1 < expected)
  - count+1 reaches expected without resp_last
- resp_start during CAPTURE:
  - abandons the current capture (staging is discarded)
  - restarts with the new type and count <= 0
  - sets err_len
  - no ack for the abandoned capture
- clr: Response_out <= 0. If clr coincides with a commit, the commit wins. clr does not affect the FSM.
- No arithmetic beyond the counter. The counter never exceeds NUM_WORDS, because an abort triggers at the expected count.

## Timing
- Reset values: Response_out = 0, busy = 0, ack = 0, err_len = 0, state IDLE, count = 0.
- resp_start sampled at cycle T: busy = 1 from T+1. The first word is accepted at T+1 at the earliest.
- Words are accepted back-to-back or with gaps. Throughput is one word per cycle.
- Last word at cycle L:
  - Response_out holds the new value from L+1
  - ack = 1 during L+1 only
  - busy = 0 from L+1
  - a new resp_start is accepted at L+1
- Error abort at cycle L: err_len = 1 from L+1, busy = 0 from L+1, Response_out unchanged.
- rst mid-capture: everything returns to reset values on the next edge and the partial data is lost.
- resp_start and resp_valid in the same IDLE cycle: the word is ignored.

## Test plan
- Reset, then long capture of words 0xAAAA0003, 0xBBBB0002, 0xCCCC0001, 0xDDDD0000 with last on the fourth -> Response_out = 0xAAAA0003_BBBB0002_CCCC0001_DDDD0000 at L+1, ack high for exactly one cycle, err_len = 0.
- From that state, short capture of 0x00000900 -> Response_out = 0xAAAA0003_BBBB0002_CCCC0001_00000900, ack pulse.
- Auto-CMD12 capture of 0x12345678 -> bits [127:96] = 0x12345678, lower 96 bits unchanged.
- Long capture with resp_last on word 2 -> err_len = 1, no ack, Response_out unchanged. Separately, a short capture with no resp_last on word 1 -> err_len = 1.
- Long capture with two words delivered, then a new resp_start (short) followed by 0x00000001 + last -> err_len = 1 after the restart, one ack only, word 0 = 0x00000001.
- clr in the same cycle as a committing last word -> committed value retained. clr in IDLE -> Response_out = 0. rst asserted mid-capture -> all outputs 0 next cycle.
